demux13_buf: RTL and testbench

- 1-to-3 routing block, the inverse of the datapath 3:1 select mux (mux31).
- Accepts one N-bit word per valid/ready handshake and steers it to one of three output channels (a, b, c) using a 2-bit control.
- Each channel has a one-entry registered holding slot.
- Used to dispatch a single result stream to several consumers, e.g. register writeback, memory store data and debug trace.

---
 rtl/demux13_buf.sv | 73 +++++++
 tb/tb_demux13_buf.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/demux13_buf.sv
// demux13_buf: steers one upstream word per handshake to channel a, b or c, each with a one-entry slot.
// A cntrl of 11 discards the word and bumps a saturating drop counter.
module demux13_buf #(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [1:0]    in_cntrl,
    output logic          out_a_valid,
    input  logic          out_a_ready,
    output logic [N-1:0]  out_a_data,
    output logic          out_b_valid,
    input  logic          out_b_ready,
    output logic [N-1:0]  out_b_data,
    output logic          out_c_valid,
    input  logic          out_c_ready,
    output logic [N-1:0]  out_c_data,
    output logic [CW-1:0] drop_cnt,
    output logic          drop_pulse
);
    logic [2:0]   v;
    logic [2:0]   r;
    logic [N-1:0] d [3];
    logic [3:0]   vq;
    logic [3:0]   rq;
    logic         xfer;
    logic         disc;

    assign r  = {out_c_ready, out_b_ready, out_a_ready};
    // The discard lane behaves as an always-empty, always-ready slot.
    assign vq = {1'b0, v};
    assign rq = {1'b1, r};
    assign in_ready = ~vq[in_cntrl] | rq[in_cntrl];
    assign xfer = in_valid & in_ready;
    assign disc = xfer & (in_cntrl == 2'b11);

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic fill;
        logic drain;
        assign fill  = xfer & (in_cntrl == 2'(g));
        assign drain = v[g] & r[g];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[g] <= 1'b0;
                d[g] <= '0;
            end else begin
                v[g] <= fill | (v[g] & ~drain);
                if (fill) d[g] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= disc;
            if (disc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_a_valid = v[0];
    assign out_b_valid = v[1];
    assign out_c_valid = v[2];
    assign out_a_data  = d[0];
    assign out_b_data  = d[1];
    assign out_c_data  = d[2];
endmodule

// File: tb/tb_demux13_buf.sv
// tb_demux13_buf: directed checks of routing, backpressure, pass-through, discard, saturation and async reset.
module tb_demux13_buf;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_cntrl = '0;
    logic        a_v, b_v, c_v;
    logic        a_r = 0, b_r = 0, c_r = 0;
    logic [31:0] a_d, b_d, c_d;
    logic [7:0]  drop_cnt;
    logic        drop_pulse;

    logic        s_valid = 0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [1:0]  s_cntrl = 2'b11;
    logic        s_av, s_bv, s_cv;
    logic        s_ar = 1, s_br = 1, s_cr = 1;
    logic [31:0] s_ad, s_bd, s_cd;
    logic [1:0]  s_cnt;
    logic        s_pulse;

    int ncheck = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    demux13_buf #(.N(32), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cntrl(in_cntrl),
        .out_a_valid(a_v), .out_a_ready(a_r), .out_a_data(a_d),
        .out_b_valid(b_v), .out_b_ready(b_r), .out_b_data(b_d),
        .out_c_valid(c_v), .out_c_ready(c_r), .out_c_data(c_d),
        .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
    );

    demux13_buf #(.N(32), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data), .in_cntrl(s_cntrl),
        .out_a_valid(s_av), .out_a_ready(s_ar), .out_a_data(s_ad),
        .out_b_valid(s_bv), .out_b_ready(s_br), .out_b_data(s_bd),
        .out_c_valid(s_cv), .out_c_ready(s_cr), .out_c_data(s_cd),
        .drop_cnt(s_cnt), .drop_pulse(s_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncheck++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valids", {a_v, b_v, c_v}, 3'b000);
        chk("rst_data", {a_d, b_d}, 64'h0);
        chk("rst_cdata", c_d, 32'h0);
        chk("rst_drop", {drop_cnt, drop_pulse}, 9'h0);
        rst_n = 1;
        step();
        // Routing with every consumer ready
        a_r = 1; b_r = 1; c_r = 1;
        in_valid = 1; in_data = 32'hAAAAAAAA; in_cntrl = 2'b00;
        #1 chk("route_ready", in_ready, 1'b1);
        step();
        chk("route_a", {a_v, a_d}, {1'b1, 32'hAAAAAAAA});
        in_data = 32'h55555555; in_cntrl = 2'b01;
        step();
        chk("route_b", {b_v, b_d}, {1'b1, 32'h55555555});
        chk("route_a_drained", a_v, 1'b0);
        in_data = 32'hFFFFFFFF; in_cntrl = 2'b10;
        step();
        chk("route_c", {c_v, c_d}, {1'b1, 32'hFFFFFFFF});
        chk("route_b_drained", b_v, 1'b0);
        in_valid = 0;
        step();
        chk("route_idle", {a_v, b_v, c_v}, 3'b000);
        // Backpressure on channel a, traffic to b still flows
        a_r = 0;
        in_valid = 1; in_data = 32'h11111111; in_cntrl = 2'b00;
        step();
        chk("bp_a_first", {a_v, a_d}, {1'b1, 32'h11111111});
        in_data = 32'h33333333; in_cntrl = 2'b01;
        #1 chk("bp_b_ready", in_ready, 1'b1);
        step();
        chk("bp_b_data", {b_v, b_d}, {1'b1, 32'h33333333});
        chk("bp_a_held", a_d, 32'h11111111);
        in_data = 32'h22222222; in_cntrl = 2'b00;
        #1 chk("bp_blocked", in_ready, 1'b0);
        step();
        chk("bp_still_blocked", in_ready, 1'b0);
        chk("bp_a_hold", {a_v, a_d}, {1'b1, 32'h11111111});
        a_r = 1;
        #1 chk("bp_unblocked", in_ready, 1'b1);
        step();
        chk("bp_a_second", {a_v, a_d}, {1'b1, 32'h22222222});
        in_valid = 0;
        step();
        chk("bp_a_drained", a_v, 1'b0);
        // Pass-through on a full channel c
        c_r = 0;
        in_valid = 1; in_data = 32'hC0C0C0C1; in_cntrl = 2'b10;
        step();
        chk("pt_c_full", {c_v, c_d}, {1'b1, 32'hC0C0C0C1});
        c_r = 1; in_data = 32'hC0C0C0C2;
        #1 chk("pt_ready", in_ready, 1'b1);
        step();
        chk("pt_c_replaced", {c_v, c_d}, {1'b1, 32'hC0C0C0C2});
        in_valid = 0;
        step();
        chk("pt_c_drained", c_v, 1'b0);
        // Five discards
        in_valid = 1; in_cntrl = 2'b11; in_data = 32'hDEADBEEF;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("disc_pulse", drop_pulse, 1'b1);
            chk("disc_cnt", drop_cnt, 8'(i));
            chk("disc_no_valid", {a_v, b_v, c_v}, 3'b000);
        end
        in_valid = 0;
        step();
        chk("disc_pulse_end", drop_pulse, 1'b0);
        chk("disc_cnt_final", drop_cnt, 8'd5);
        // Saturation on the CW=2 instance
        s_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("sat_cnt", s_cnt, (i > 3) ? 2'd3 : 2'(i));
        end
        s_valid = 0;
        // Asynchronous reset with channel a full
        a_r = 0; in_valid = 1; in_cntrl = 2'b00; in_data = 32'h12345678;
        step();
        chk("areset_pre", {a_v, a_d}, {1'b1, 32'h12345678});
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("areset_valids", {a_v, b_v, c_v}, 3'b000);
        chk("areset_drop", drop_cnt, 8'd0);
        chk("areset_data", a_d, 32'h0);
        chk("areset_sat", s_cnt, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
        $finish;
    end
endmodule
